// File: rtl/fifo_sc_param.sv
// Single-clock parametrised FIFO with FWFT/standard read modes, occupancy count,
// programmable thresholds and sticky error flags. Define FIFO_HWM_EN to add the HWM output.
module fifo_sc_param #(
  parameter int W                 = 64,
  parameter int DEPTH             = 512,
  parameter int FWFT              = 1,
  parameter int PROG_FULL_THRESH  = DEPTH - 4,
  parameter int PROG_EMPTY_THRESH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic [W-1:0]             DIN,
  input  logic                     WREN,
  output logic                     FULL_N,
  input  logic                     RDEN,
  output logic [W-1:0]             DOUT,
  output logic                     EMPTY_N,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     PROG_FULL,
  output logic                     PROG_EMPTY,
  output logic                     OVF,
`ifdef FIFO_HWM_EN
  output logic                     UDF,
  output logic [$clog2(DEPTH):0]   HWM
`else
  output logic                     UDF
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_n_q, empty_n_d, full_n_q, full_n_d;
  logic          prog_full_q, prog_full_d, prog_empty_q, prog_empty_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          wr_acc, rd_acc;

  // Acceptance uses the registered handshake outputs seen before the edge.
  assign wr_acc = WREN & full_n_q;
  assign rd_acc = RDEN & empty_n_q;

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (!wr_acc && rd_acc) count_d = count_q - CW'(1);
    ovf_d = ovf_q | (WREN & (count_q == CW'(DEPTH)));
    udf_d = udf_q | (RDEN & (count_q == '0));
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
    empty_n_d    = (count_d != '0);
    full_n_d     = (count_d != CW'(DEPTH));
    prog_full_d  = (count_d >= CW'(PROG_FULL_THRESH));
    prog_empty_d = (count_d <= CW'(PROG_EMPTY_THRESH));
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic [W-1:0] head;
      // The head changes only when it is popped or when the FIFO was empty;
      // a write landing in the new head slot bypasses the array.
      always_comb begin
        head   = (wr_acc && (rd_ptr_d == wr_ptr_q)) ? DIN : mem[rd_ptr_d];
        dout_d = dout_q;
        if (CLR)
          dout_d = '0;
        else if ((count_d != '0) && (rd_acc || !empty_n_q))
          dout_d = head;
      end
    end else begin : g_std
      always_comb begin
        dout_d = dout_q;
        if (CLR)         dout_d = '0;
        else if (rd_acc) dout_d = mem[rd_ptr_q];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST && !CLR && wr_acc)
      mem[wr_ptr_q] <= DIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_n_q    <= 1'b0;
      full_n_q     <= 1'b0;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      dout_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_n_q    <= empty_n_d;
      full_n_q     <= full_n_d;
      prog_full_q  <= prog_full_d;
      prog_empty_q <= prog_empty_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      dout_q       <= dout_d;
    end
  end

`ifdef FIFO_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    if (CLR) hwm_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign HWM = hwm_q;
`endif

  assign FULL_N     = full_n_q;
  assign EMPTY_N    = empty_n_q;
  assign COUNT      = count_q;
  assign PROG_FULL  = prog_full_q;
  assign PROG_EMPTY = prog_empty_q;
  assign OVF        = ovf_q;
  assign UDF        = udf_q;
  assign DOUT       = dout_q;

endmodule

// File: tb/tb_fifo_sc_param.sv
// Directed bench for fifo_sc_param: a 72x16 FWFT instance and an 8x8 standard-mode instance.
module tb_fifo_sc_param;

  localparam logic [71:0] BASE = 72'h1_0000_0000_0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        a_clr = 1'b0, a_wren = 1'b0, a_rden = 1'b0;
  logic [71:0] a_din = '0;
  logic [71:0] a_dout;
  logic        a_full_n, a_empty_n, a_pf, a_pe, a_ovf, a_udf;
  logic [4:0]  a_count;

  logic        b_clr = 1'b0, b_wren = 1'b0, b_rden = 1'b0;
  logic [7:0]  b_din = '0;
  logic [7:0]  b_dout;
  logic        b_full_n, b_empty_n, b_pf, b_pe, b_ovf, b_udf;
  logic [3:0]  b_count;
`ifdef FIFO_HWM_EN
  logic [4:0]  a_hwm;
  logic [3:0]  b_hwm;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  fifo_sc_param #(.W(72), .DEPTH(16), .FWFT(1), .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) u_a (
    .CLK(CLK), .RST(RST), .CLR(a_clr), .DIN(a_din), .WREN(a_wren), .FULL_N(a_full_n),
    .RDEN(a_rden), .DOUT(a_dout), .EMPTY_N(a_empty_n), .COUNT(a_count),
    .PROG_FULL(a_pf), .PROG_EMPTY(a_pe), .OVF(a_ovf),
`ifdef FIFO_HWM_EN
    .UDF(a_udf), .HWM(a_hwm)
`else
    .UDF(a_udf)
`endif
  );

  fifo_sc_param #(.W(8), .DEPTH(8), .FWFT(0)) u_b (
    .CLK(CLK), .RST(RST), .CLR(b_clr), .DIN(b_din), .WREN(b_wren), .FULL_N(b_full_n),
    .RDEN(b_rden), .DOUT(b_dout), .EMPTY_N(b_empty_n), .COUNT(b_count),
    .PROG_FULL(b_pf), .PROG_EMPTY(b_pe), .OVF(b_ovf),
`ifdef FIFO_HWM_EN
    .UDF(b_udf), .HWM(b_hwm)
`else
    .UDF(b_udf)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         nwr;

  initial begin
    // Reset state
    tick();
    chk("rst_count", a_count, 0);
    chk("rst_empty_n", a_empty_n, 0);
    chk("rst_full_n", a_full_n, 0);
    chk("rst_prog_empty", a_pe, 1);
    chk("rst_prog_full", a_pf, 0);
    chk("rst_ovf_udf", {a_ovf, a_udf}, 0);
    chk("rst_dout_a", a_dout, 0);
    chk("rst_dout_b", b_dout, 0);
    RST = 1'b0;
    tick();
    chk("full_n_after_rst", a_full_n, 1);

    // Fill A with 16 consecutive values
    a_wren = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_din = BASE + 72'(i);
      tick();
      chk($sformatf("fill_count[%0d]", i), a_count, i + 1);
      chk($sformatf("fill_prog_full[%0d]", i), a_pf, (i + 1) >= 12);
      chk($sformatf("fill_full_n[%0d]", i), a_full_n, i != 15);
    end
    chk("fill_empty_n", a_empty_n, 1);
    chk("fill_head", a_dout, BASE);
`ifdef FIFO_HWM_EN
    chk("hwm_full", a_hwm, 16);
`endif

    // Full with WREN and RDEN: read taken, write dropped, OVF sets
    a_din  = BASE + 72'd99;
    a_rden = 1'b1;
    tick();
    a_wren = 1'b0;
    chk("full_rw_count", a_count, 15);
    chk("full_rw_ovf", a_ovf, 1);
    chk("full_rw_udf", a_udf, 0);

    // Drain the remaining 15 entries in order
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("drain_dout[%0d]", k), a_dout, BASE + 72'(k));
      tick();
      chk($sformatf("drain_count[%0d]", k), a_count, 15 - k);
      chk($sformatf("drain_prog_empty[%0d]", k), a_pe, (15 - k) <= 4);
    end
    a_rden = 1'b0;
    chk("drained_empty_n", a_empty_n, 0);
    chk("drained_full_n", a_full_n, 1);

    // Empty with WREN and RDEN: write taken, read dropped, UDF sets
    a_wren = 1'b1; a_rden = 1'b1; a_din = 72'h77;
    tick();
    a_rden = 1'b0;
    chk("empty_rw_count", a_count, 1);
    chk("empty_rw_udf", a_udf, 1);
    chk("empty_rw_dout", a_dout, 72'h77);

    // Bring COUNT to 5 then CLR with a concurrent write
    for (int i = 0; i < 4; i++) begin
      a_din = 72'h80 + 72'(i);
      tick();
    end
    chk("pre_clr_count", a_count, 5);
    chk("pre_clr_ovf", a_ovf, 1);
    a_clr = 1'b1; a_din = 72'hDEAD;
    tick();
    a_clr = 1'b0; a_wren = 1'b0;
    chk("clr_count", a_count, 0);
    chk("clr_ovf", a_ovf, 0);
    chk("clr_udf", a_udf, 0);
    chk("clr_empty_n", a_empty_n, 0);
    chk("clr_full_n", a_full_n, 1);
    chk("clr_dout", a_dout, 0);
`ifdef FIFO_HWM_EN
    chk("clr_hwm", a_hwm, 0);
`endif
    a_wren = 1'b1; a_din = 72'h55;
    tick();
    a_wren = 1'b0;
    chk("post_clr_count", a_count, 1);
    chk("post_clr_dout", a_dout, 72'h55);

    // Standard read mode on B
    b_wren = 1'b1; b_din = 8'hA5;
    tick();
    b_din = 8'h5A;
    tick();
    b_wren = 1'b0;
    chk("b_count2", b_count, 2);
    chk("b_empty_n", b_empty_n, 1);
    chk("b_dout_before_read", b_dout, 0);
    b_rden = 1'b1;
    tick();
    chk("b_read1", b_dout, 8'hA5);
    tick();
    b_rden = 1'b0;
    chk("b_read2", b_dout, 8'h5A);
    tick();
    chk("b_hold", b_dout, 8'h5A);
    chk("b_empty_after", b_empty_n, 0);

    // Interleaved traffic on B with occupancy kept in 1..7
    b_wren = 1'b1; b_din = 8'h3C;
    tick();
    sb.push_back(8'h3C);
    nwr = 1;
    for (int c = 0; c < 40; c++) begin
      logic wr, rd;
      wr = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 1) != 0);
      if (sb.size() == 1 && rd && !wr) wr = 1'b1;
      if (sb.size() == 7 && wr && !rd) rd = 1'b1;
      b_wren = wr; b_rden = rd; b_din = 8'($urandom);
      exp_b = b_dout;
      if (rd) exp_b = sb.pop_front();
      if (wr) begin
        sb.push_back(b_din);
        nwr++;
      end
      tick();
      chk($sformatf("wrap_count[%0d]", c), b_count, sb.size());
      chk($sformatf("wrap_dout[%0d]", c), b_dout, exp_b);
    end
    b_wren = 1'b0; b_rden = 1'b0;
    $display("wrap phase: %0d writes into depth 8", nwr);

    // RST with a concurrent write on A at COUNT=5
    a_wren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_din = 72'h90 + 72'(i);
      tick();
    end
    chk("pre_rst_count", a_count, 5);
    RST = 1'b1; a_din = 72'hBEEF;
    tick();
    chk("rst2_count", a_count, 0);
    chk("rst2_full_n", a_full_n, 0);
    chk("rst2_empty_n", a_empty_n, 0);
    chk("rst2_dout", a_dout, 0);
`ifdef FIFO_HWM_EN
    chk("rst2_hwm", a_hwm, 0);
`endif
    RST = 1'b0;
    tick();
    a_wren = 1'b0;
    chk("rst2_release_full_n", a_full_n, 1);
    chk("rst2_release_count", a_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_sc_param.md
Name: fifo_sc_param

Overview:
Single-clock, parametrised synchronous FIFO built from inferred RAM or registers. It generalises the fixed-width block-RAM FIFO wrapper to any width and any power-of-two depth, with a selectable read mode. It adds occupancy count, programmable thresholds and sticky overflow/underflow flags. It sits between BSV-generated producers and consumers and uses the same EMPTY_N/FULL_N ready-style handshake.

Parameters:
W, 64, data width in bits, 1..1024.
DEPTH, 512, number of entries; power of two, 2..65536.
FWFT, 1, read mode: 1 = first-word-fall-through, 0 = standard (data one cycle after RDEN).
PROG_FULL_THRESH, DEPTH-4, PROG_FULL asserts when COUNT >= this value.
PROG_EMPTY_THRESH, 4, PROG_EMPTY asserts when COUNT <= this value.

Ports:
CLK  input  1  clock; all logic on the rising edge.
RST  input  1  synchronous, active-high reset.
CLR  input  1  synchronous flush; empties the FIFO and clears the error flags.
DIN  input  W  write data.
WREN  input  1  write request.
FULL_N  output  1  1 = space available.
RDEN  input  1  read request (pop).
DOUT  output  W  read data.
EMPTY_N  output  1  1 = data available.
COUNT  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
PROG_FULL  output  1  COUNT >= PROG_FULL_THRESH.
PROG_EMPTY  output  1  COUNT <= PROG_EMPTY_THRESH.
OVF  output  1  sticky: a write was attempted while full.
UDF  output  1  sticky: a read was attempted while empty.

Behaviour:
- Storage and pointers:
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - COUNT is held in its own register, not derived from pointer difference.
- Acceptance rules (all decided on pre-edge output values):
  - A write is accepted iff WREN & FULL_N.
  - A read is accepted iff RDEN & EMPTY_N.
- Simultaneous read and write:
  - Both accepted: COUNT is unchanged and both pointers advance.
  - When full, WREN & RDEN: the read is accepted and the write is dropped; OVF sets.
  - When empty, WREN & RDEN: the write is accepted and the read is dropped; UDF sets.
- Registered status:
  - EMPTY_N, FULL_N, COUNT, PROG_FULL, PROG_EMPTY, OVF and UDF are all registered.
  - They are updated on the same edge as the accepted operation, computed from next-state COUNT.
- FWFT=1:
  - DOUT presents the head entry whenever EMPTY_N=1.
  - Write-to-EMPTY_N latency is 1 edge: a write into an empty FIFO at edge N makes EMPTY_N=1 and DOUT valid after edge N.
  - A read at edge N presents the next entry after edge N.
  - DOUT is don't-care while EMPTY_N=0; the implementation holds the last value.
- FWFT=0:
  - An accepted read loads the head entry into the DOUT register at that edge.
  - DOUT holds its value otherwise.
  - EMPTY_N is true occupancy (COUNT != 0).
- Reset (RST=1):
  - Pointers and COUNT = 0; DOUT = 0.
  - EMPTY_N = 0, FULL_N = 0 (no writes accepted during reset).
  - PROG_EMPTY = 1, PROG_FULL = 0, OVF = 0, UDF = 0.
  - FULL_N rises on the first edge with RST=0.
- CLR=1, RST=0:
  - Same state as reset, except FULL_N = 1 immediately after the edge.
  - Storage contents are not cleared.
- Priority: RST > CLR > WREN/RDEN. Any WREN/RDEN in a RST or CLR cycle is ignored and does not set OVF/UDF.
- Reset mid-stream: all queued data is discarded. There is no partial or early release.
- Threshold configurations: thresholds equal to 0 or DEPTH are legal. PROG_FULL_THRESH=0 makes PROG_FULL constantly 1 outside reset.

Optional Feature:
Macro FIFO_HWM_EN.
- Defined:
  - Adds output HWM, width $clog2(DEPTH)+1: the maximum COUNT reached since the last RST or CLR.
  - HWM is registered and updated on the same edge as COUNT.
  - HWM resets to 0.
- Undefined:
  - The HWM port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- W=72, DEPTH=16, FWFT=1. Write 0x1_0000_0000_0000_0000..+15 on consecutive cycles, then pop all -> FULL_N=0 after the 16th write; COUNT=16; DOUT returns all 16 values in order; EMPTY_N=0 after the 16th pop; COUNT=0.
- DEPTH=16 full, WREN=RDEN=1 for one cycle -> COUNT=15, OVF=1, UDF=0. Then empty the FIFO and drive WREN=RDEN=1 -> COUNT=1, UDF=1.
- FWFT=0, write 0xA5 then 0x5A, pulse RDEN twice -> DOUT=0xA5 after the first read edge and 0x5A after the second; DOUT holds 0x5A afterwards.
- DEPTH=16, PROG_FULL_THRESH=12, PROG_EMPTY_THRESH=4. Fill to 12, drain to 4 -> PROG_FULL rises on the edge where COUNT becomes 12; PROG_EMPTY rises on the edge where COUNT becomes 4.
- Wrap-around: 40 random interleaved write/read cycles on DEPTH=8 with occupancy kept at 1..7 -> data order preserved across at least 3 pointer wraps; COUNT matches the scoreboard every cycle.
- With COUNT=5 and OVF=1, assert CLR together with WREN -> after the edge: COUNT=0, OVF=0, EMPTY_N=0, FULL_N=1, and the write is not stored. Repeat with RST -> FULL_N=0 for the reset cycle. Under FIFO_HWM_EN, HWM returns to 0 in both cases.
